// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster timing generator.
// Holds the 640x480@60 and 800x600@60 mode tables and the line/frame total helper.
package vga_timing_pkg;

  // Total length of one axis: active + front porch + sync + back porch.
  function automatic int tot(input int a, input int fp, input int s, input int bp);
    return a + fp + s + bp;
  endfunction

  // 640x480 @ 60 Hz, 25.175 MHz pixel rate, both syncs active-low.
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel rate, both syncs active-high.
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;

  // Default frame counter width.
  localparam int DEF_FCNT_W = 8;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical): position counter with exact wrap,
// plus sync level, active flag and clamped coordinate decoded from the next
// position so the registered outputs line up with the counter itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  localparam int TOTAL = tot(ACTIVE, FP, SYNC, BP),
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_adv,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_sync,
  output logic         o_active_next,
  output logic [W-1:0] o_coord
);

  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
  localparam logic [W-1:0] COORD_MAX = W'(ACTIVE - 1);
  localparam int           SYNC_LO   = ACTIVE + FP;
  localparam int           SYNC_HI   = ACTIVE + FP + SYNC;

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic [W-1:0] coord_reg;
  logic [W-1:0] coord_next;
  logic         sync_reg;
  logic         sync_next;
  logic         active_next;
  int           pos_next;

  // Next position: hold without advance, wrap exactly at the last position.
  always_comb begin
    count_next = count_reg;
    if (i_adv) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + W'(1);
    end
  end

  // Decode sync, active and clamped coordinate from the next position.
  always_comb begin
    pos_next    = int'(count_next);
    active_next = (pos_next < ACTIVE);
    sync_next   = ((pos_next >= SYNC_LO) && (pos_next < SYNC_HI)) ? POL : ~POL;
    coord_next  = active_next ? count_next : COORD_MAX;
  end

  // Position and decoded outputs; reset parks at the last position.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= LAST;
      sync_reg  <= ~POL;
      coord_reg <= COORD_MAX;
    end else begin
      count_reg <= count_next;
      sync_reg  <= sync_next;
      coord_reg <= coord_next;
    end
  end

  assign o_count       = count_reg;
  assign o_wrap        = (count_reg == LAST);
  assign o_sync        = sync_reg;
  assign o_active_next = active_next;
  assign o_coord       = coord_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Two axis counters (V advances on
// H wrap), park/run control at the frame boundary, one-clock event pulses and
// a wrapping frame counter. All outputs are registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL,
  parameter int FCNT_W   = DEF_FCNT_W,
  localparam int H_TOTAL = tot(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = tot(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_stb,
  input  logic              i_en,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [XW-1:0]     o_x,
  output logic [YW-1:0]     o_y,
  output logic              o_line_start,
  output logic              o_frame_start,
  output logic              o_animate,
  output logic [FCNT_W-1:0] o_frame_cnt
);

  localparam logic [XW-1:0] H_LAST      = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST      = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST_VIS  = YW'(V_ACTIVE - 1);

  logic [XW-1:0]     h_count;
  logic [YW-1:0]     v_count;
  logic              h_wrap;
  logic              v_wrap;
  logic              h_active_next;
  logic              v_active_next;
  logic              park_pos;
  logic              park_hold;
  logic              adv_h;
  logic              adv_v;

  logic              de_reg;
  logic              de_next;
  logic              line_start_reg;
  logic              line_start_next;
  logic              frame_start_reg;
  logic              frame_start_next;
  logic              animate_reg;
  logic              animate_next;
  logic [FCNT_W-1:0] frame_cnt_reg;
  logic [FCNT_W-1:0] frame_cnt_next;

  // At the last raster position a low enable swallows strobes, so the
  // generator parks between frames with both syncs inactive (back porch).
  assign park_pos  = (h_count == H_LAST) && (v_count == V_LAST);
  assign park_hold = park_pos && !i_en;
  assign adv_h     = i_pix_stb && !park_hold;
  assign adv_v     = adv_h && h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_adv         (adv_h),
    .o_count       (h_count),
    .o_wrap        (h_wrap),
    .o_sync        (o_hs),
    .o_active_next (h_active_next),
    .o_coord       (o_x)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_adv         (adv_v),
    .o_count       (v_count),
    .o_wrap        (v_wrap),
    .o_sync        (o_vs),
    .o_active_next (v_active_next),
    .o_coord       (o_y)
  );

  // Event detection on the advancing edge; pulses last one clock because the
  // position cannot re-enter the same point on the following clock.
  always_comb begin
    de_next          = h_active_next && v_active_next;
    line_start_next  = adv_v;
    frame_start_next = adv_v && v_wrap;
    animate_next     = adv_v && (v_count == V_LAST_VIS);
    frame_cnt_next   = frame_cnt_reg;
    if (frame_start_next) begin
      frame_cnt_next = frame_cnt_reg + FCNT_W'(1);
    end
  end

  // Registered data-enable, pulses and frame counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      animate_reg     <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      de_reg          <= de_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      animate_reg     <= animate_next;
      frame_cnt_reg   <= frame_cnt_next;
    end
  end

  assign o_de          = de_reg;
  assign o_line_start  = line_start_reg;
  assign o_frame_start = frame_start_reg;
  assign o_animate     = animate_reg;
  assign o_frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 640x480 instance and a tiny
// 7x5 instance, each tracked by a raster-position reference model.
module tb_vga_timing_gen;

  // Default mode geometry
  localparam int DHA = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVA = 480, DVF = 10, DVS = 2,  DVB = 33;
  localparam int DHT = DHA + DHF + DHS + DHB;
  localparam int DVT = DVA + DVF + DVS + DVB;
  // Tiny mode geometry (HS active-high, VS active-low, 2-bit frame counter)
  localparam int SHA = 4, SHF = 1, SHS = 1, SHB = 1;
  localparam int SVA = 2, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  typedef struct {
    int h;
    int v;
    int fcnt;
    bit ls;
    bit fs;
    bit an;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_d, stb_d, en_d;
  logic       d_hs, d_vs, d_de, d_ls, d_fs, d_an;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fcnt;
  logic       rst_n_s, stb_s, en_s;
  logic       s_hs, s_vs, s_de, s_ls, s_fs, s_an;
  logic [2:0] s_x, s_y;
  logic [1:0] s_fcnt;

  logic [33:0] act_d;
  logic [13:0] act_s;
  assign act_d = {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs, d_an, d_fcnt};
  assign act_s = {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_an, s_fcnt};

  int   n_cmp = 0;
  int   n_bad = 0;
  mdl_t md;
  mdl_t ms;

  vga_timing_gen dut_d (
    .i_clk         (clk),
    .i_rst_n       (rst_n_d),
    .i_pix_stb     (stb_d),
    .i_en          (en_d),
    .o_hs          (d_hs),
    .o_vs          (d_vs),
    .o_de          (d_de),
    .o_x           (d_x),
    .o_y           (d_y),
    .o_line_start  (d_ls),
    .o_frame_start (d_fs),
    .o_animate     (d_an),
    .o_frame_cnt   (d_fcnt)
  );

  vga_timing_gen #(
    .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
    .HS_POL   (1'b1), .VS_POL (1'b0), .FCNT_W (2)
  ) dut_s (
    .i_clk         (clk),
    .i_rst_n       (rst_n_s),
    .i_pix_stb     (stb_s),
    .i_en          (en_s),
    .o_hs          (s_hs),
    .o_vs          (s_vs),
    .o_de          (s_de),
    .o_x           (s_x),
    .o_y           (s_y),
    .o_line_start  (s_ls),
    .o_frame_start (s_fs),
    .o_animate     (s_an),
    .o_frame_cnt   (s_fcnt)
  );

  // Reference model: raster position plus last-step events.
  function automatic mdl_t mdl_reset(input int ht, input int vt);
    mdl_t r;
    r.h = ht - 1; r.v = vt - 1; r.fcnt = 0;
    r.ls = 1'b0; r.fs = 1'b0; r.an = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int ht, input int vt,
                                    input int va, input int fmod,
                                    input bit stb, input bit en);
    mdl_t r;
    r = m;
    r.ls = 1'b0; r.fs = 1'b0; r.an = 1'b0;
    if (stb && !(!en && m.h == ht - 1 && m.v == vt - 1)) begin
      r.h = (m.h + 1) % ht;
      if (r.h == 0) r.v = (m.v + 1) % vt;
      r.ls = (r.h == 0);
      r.fs = r.ls && (r.v == 0);
      r.an = r.ls && (r.v == va);
      if (r.fs) r.fcnt = (m.fcnt + 1) % fmod;
    end
    return r;
  endfunction

  function automatic logic [33:0] exp_d(input mdl_t m);
    logic hs, vs, de;
    logic [9:0] x, y;
    hs = (m.h >= DHA + DHF && m.h < DHA + DHF + DHS) ? 1'b0 : 1'b1;
    vs = (m.v >= DVA + DVF && m.v < DVA + DVF + DVS) ? 1'b0 : 1'b1;
    de = (m.h < DHA) && (m.v < DVA);
    x  = (m.h < DHA) ? 10'(m.h) : 10'(DHA - 1);
    y  = (m.v < DVA) ? 10'(m.v) : 10'(DVA - 1);
    return {hs, vs, de, x, y, m.ls, m.fs, m.an, 8'(m.fcnt)};
  endfunction

  function automatic logic [13:0] exp_s(input mdl_t m);
    logic hs, vs, de;
    logic [2:0] x, y;
    hs = (m.h >= SHA + SHF && m.h < SHA + SHF + SHS) ? 1'b1 : 1'b0;
    vs = (m.v >= SVA + SVF && m.v < SVA + SVF + SVS) ? 1'b0 : 1'b1;
    de = (m.h < SHA) && (m.v < SVA);
    x  = (m.h < SHA) ? 3'(m.h) : 3'(SHA - 1);
    y  = (m.v < SVA) ? 3'(m.v) : 3'(SVA - 1);
    return {hs, vs, de, x, y, m.ls, m.fs, m.an, 2'(m.fcnt)};
  endfunction

  task automatic step_d(input bit stb, input bit en);
    stb_d = stb; en_d = en;
    @(posedge clk); #1;
    md = mdl_next(md, DHT, DVT, DVA, 256, stb, en);
  endtask

  task automatic step_s(input bit stb, input bit en);
    stb_s = stb; en_s = en;
    @(posedge clk); #1;
    ms = mdl_next(ms, SHT, SVT, SVA, 4, stb, en);
  endtask

  task automatic test_reset();
    rst_n_d = 1'b0; rst_n_s = 1'b0;
    stb_d = 1'b0; stb_s = 1'b0; en_d = 1'b1; en_s = 1'b1;
    #12;
    md = mdl_reset(DHT, DVT);
    ms = mdl_reset(SHT, SVT);
    n_cmp++;
    if (act_d !== exp_d(md)) begin
      n_bad++; $display("FAIL reset_d: got %h want %h", act_d, exp_d(md));
    end
    n_cmp++;
    if (act_s !== exp_s(ms)) begin
      n_bad++; $display("FAIL reset_s: got %h want %h", act_s, exp_s(ms));
    end
    @(negedge clk);
    rst_n_d = 1'b1; rst_n_s = 1'b1;
    step_d(1'b0, 1'b1);
    n_cmp++;
    if (act_d !== exp_d(md)) begin
      n_bad++; $display("FAIL reset_hold_d: got %h want %h", act_d, exp_d(md));
    end
    $display("test_reset: done");
  endtask

  task automatic test_first_strobe();
    for (int i = 0; i < 8; i++) begin
      step_d((i % 4) == 3, 1'b1);
      n_cmp++;
      if (act_d !== exp_d(md)) begin
        n_bad++; $display("FAIL first_strobe[%0d]: got %h want %h", i, act_d, exp_d(md));
      end
      if (i == 3) begin
        n_cmp++;
        if ({d_fs, d_ls, d_de, d_x, d_y, d_fcnt} !== {1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 8'd1}) begin
          n_bad++;
          $display("FAIL first_frame: fs=%b ls=%b de=%b x=%0d y=%0d cnt=%0d want 1 1 1 0 0 1",
                   d_fs, d_ls, d_de, d_x, d_y, d_fcnt);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if ({d_fs, d_ls} !== 2'b00) begin
          n_bad++; $display("FAIL pulse_width: fs=%b ls=%b want 0 0", d_fs, d_ls);
        end
      end
    end
    $display("test_first_strobe: done");
  endtask

  task automatic test_line_scan();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
    int last_ls = -1, period = -1;
    bit e;
    // Position is (1,0); 1599 strobes reach (0,2).
    for (int s = 1; s <= 1599; s++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        e = 1'($urandom_range(0, 1));
        step_d(1'b0, e);
        n_cmp++;
        if (act_d !== exp_d(md)) begin
          n_bad++; $display("FAIL line_idle: got %h want %h", act_d, exp_d(md));
        end
      end
      e = 1'($urandom_range(0, 1));
      step_d(1'b1, e);
      n_cmp++;
      if (act_d !== exp_d(md)) begin
        n_bad++; $display("FAIL line_stb(%0d,%0d): got %h want %h", md.h, md.v, act_d, exp_d(md));
      end
      if (md.v == 1) begin
        if (d_de) de_cnt++;
        if (!d_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = md.h;
          hs_last = md.h;
        end
      end
      if (d_ls) begin
        if (last_ls >= 0) period = s - last_ls;
        last_ls = s;
      end
    end
    n_cmp++;
    if (de_cnt != 640) begin
      n_bad++; $display("FAIL de_per_line: got %0d want 640", de_cnt);
    end
    n_cmp++;
    if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
      n_bad++; $display("FAIL hs_window: got %0d [%0d..%0d] want 96 [656..751]", hs_cnt, hs_first, hs_last);
    end
    n_cmp++;
    if (period != 800) begin
      n_bad++; $display("FAIL line_period: got %0d want 800", period);
    end
    $display("test_line_scan: done");
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 50; i++) step_d(1'b1, 1'b1);
    n_cmp++;
    if (act_d !== exp_d(md)) begin
      n_bad++; $display("FAIL pre_reset: got %h want %h", act_d, exp_d(md));
    end
    @(posedge clk); #3;
    rst_n_d = 1'b0;
    #1;
    n_cmp++;
    if ({d_de, d_hs, d_vs, d_x, d_y, d_ls, d_fs, d_an, d_fcnt} !==
        {1'b0, 1'b1, 1'b1, 10'd639, 10'd479, 3'b000, 8'd0}) begin
      n_bad++;
      $display("FAIL async_reset: de=%b hs=%b vs=%b x=%0d y=%0d cnt=%0d want 0 1 1 639 479 0",
               d_de, d_hs, d_vs, d_x, d_y, d_fcnt);
    end
    md = mdl_reset(DHT, DVT);
    @(negedge clk);
    rst_n_d = 1'b1;
    step_d(1'b1, 1'b1);
    n_cmp++;
    if ({d_fs, d_fcnt, d_x, d_y} !== {1'b1, 8'd1, 10'd0, 10'd0} || act_d !== exp_d(md)) begin
      n_bad++; $display("FAIL restart: got %h want %h", act_d, exp_d(md));
    end
    stb_d = 1'b0;
    $display("test_reset_midline: done");
  endtask

  task automatic test_small_frames();
    int fs_cnt = 0, bad_period = 0, last_fs = -1, an_cnt = 0;
    int hs_hi = 0, vs_lo = 0;
    bit wrap_seen = 1'b0;
    logic [1:0] prev;
    stb_d = 1'b0;
    for (int k = 1; k <= 180; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step_s(1'b0, 1'b1);
        n_cmp++;
        if (act_s !== exp_s(ms)) begin
          n_bad++; $display("FAIL small_idle: got %h want %h", act_s, exp_s(ms));
        end
      end
      prev = s_fcnt;
      step_s(1'b1, 1'b1);
      n_cmp++;
      if (act_s !== exp_s(ms)) begin
        n_bad++; $display("FAIL small_stb(%0d,%0d): got %h want %h", ms.h, ms.v, act_s, exp_s(ms));
      end
      if (s_fs) begin
        fs_cnt++;
        if (last_fs >= 0 && k - last_fs != 35) bad_period++;
        last_fs = k;
        if (prev == 2'd3 && s_fcnt == 2'd0) wrap_seen = 1'b1;
      end
      if (s_an) an_cnt++;
      if (s_hs) hs_hi++;
      if (!s_vs) vs_lo++;
    end
    n_cmp++;
    if (fs_cnt != 6 || bad_period != 0) begin
      n_bad++; $display("FAIL frame_period: frames=%0d bad=%0d want 6 0", fs_cnt, bad_period);
    end
    n_cmp++;
    if (an_cnt != 5) begin
      n_bad++; $display("FAIL animate_count: got %0d want 5", an_cnt);
    end
    n_cmp++;
    if (hs_hi != 25 || vs_lo != 35) begin
      n_bad++; $display("FAIL small_sync: hs_hi=%0d vs_lo=%0d want 25 35", hs_hi, vs_lo);
    end
    n_cmp++;
    if (!wrap_seen) begin
      n_bad++; $display("FAIL fcnt_wrap: got no 3->0 want 3->0");
    end
    $display("test_small_frames: done");
  endtask

  task automatic test_park();
    int pulses = 0;
    // Position is (4,0); drop enable mid-frame and keep strobing.
    for (int k = 0; k < 60; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step_s(1'b0, 1'b0);
      step_s(1'b1, 1'b0);
      n_cmp++;
      if (act_s !== exp_s(ms)) begin
        n_bad++; $display("FAIL park_stb: got %h want %h", act_s, exp_s(ms));
      end
      if (k >= 40 && (s_ls || s_fs || s_an || s_hs)) pulses++;
    end
    n_cmp++;
    if ({s_x, s_y, s_hs, s_vs, s_de, s_fcnt} !== {3'd3, 3'd1, 1'b0, 1'b1, 1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL parked: x=%0d y=%0d hs=%b vs=%b de=%b cnt=%0d want 3 1 0 1 0 2",
               s_x, s_y, s_hs, s_vs, s_de, s_fcnt);
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++; $display("FAIL parked_quiet: got %0d events want 0", pulses);
    end
    step_s(1'b0, 1'b1);
    step_s(1'b1, 1'b1);
    n_cmp++;
    if ({s_fs, s_fcnt, s_x, s_y} !== {1'b1, 2'd3, 3'd0, 3'd0} || act_s !== exp_s(ms)) begin
      n_bad++; $display("FAIL resume: got %h want %h", act_s, exp_s(ms));
    end
    $display("test_park: done");
  endtask

  task automatic test_back_to_back();
    bit stb, e;
    for (int i = 0; i < 400; i++) begin
      stb = ($urandom_range(0, 3) != 0);
      e   = ($urandom_range(0, 3) != 0);
      step_s(stb, e);
      n_cmp++;
      if (act_s !== exp_s(ms)) begin
        n_bad++; $display("FAIL b2b[%0d]: got %h want %h", i, act_s, exp_s(ms));
      end
    end
    $display("test_back_to_back: done");
  endtask

  initial begin
    test_reset();
    test_first_strobe();
    test_line_scan();
    test_reset_midline();
    test_small_frames();
    test_park();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
